// File: rtl/column_feed_ctrl.sv
// Column feed sequencer: walks tiles x columns, issues one column-buffer read per column,
// and presents the framing flags aligned to the 1-cycle buffer data. Optional perf counters: COLUMN_FEED_PERF_EN.
module column_feed_ctrl #(
  parameter int COL_W  = 10,
  parameter int TILE_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [COL_W-1:0]  cfg_num_cols,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              pack_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              column_valid,
  output logic              col_first,
  output logic              col_last,
  output logic              tile_last,
  output logic              busy,
  output logic              done,
`ifdef COLUMN_FEED_PERF_EN
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_issue_cycles,
`endif
  output logic              cfg_err
);

  // state | meaning
  // IDLE  | waiting for start; zero-count starts are rejected here
  // RUN   | issuing one read per cycle while pack_ready is high
  // DRAIN | final column's data is on the bus; done pulses
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [COL_W-1:0]  COL_ONE  = 1;
  localparam logic [TILE_W-1:0] TILE_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  logic [COL_W-1:0]  col_cnt;
  logic [TILE_W-1:0] tile_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [COL_W-1:0]  num_cols_r;
  logic [TILE_W-1:0] num_tiles_r;
  logic              cv_r, first_r, last_r, tl_r;
  logic              done_r, err_r;

  logic issue, col_end, tile_end, cfg_zero;

  // Issue is combinational on pack_ready so a low ready blocks the same cycle.
  always_comb begin
    issue    = (state == RUN) && pack_ready && !abort;
    col_end  = (col_cnt == num_cols_r - COL_ONE);
    tile_end = (tile_cnt == num_tiles_r - TILE_ONE);
    cfg_zero = (cfg_num_cols == '0) || (cfg_num_tiles == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      col_cnt     <= '0;
      tile_cnt    <= '0;
      addr_r      <= '0;
      num_cols_r  <= '0;
      num_tiles_r <= '0;
      cv_r        <= 1'b0;
      first_r     <= 1'b0;
      last_r      <= 1'b0;
      tl_r        <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      cv_r    <= issue;
      first_r <= issue && (col_cnt == '0);
      last_r  <= issue && col_end;
      tl_r    <= issue && tile_end;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_zero) begin
                err_r  <= 1'b1;
                done_r <= 1'b1;
              end else begin
                num_cols_r  <= cfg_num_cols;
                num_tiles_r <= cfg_num_tiles;
                col_cnt     <= '0;
                tile_cnt    <= '0;
                addr_r      <= cfg_base_addr;
                state       <= RUN;
              end
            end
          end
          RUN: begin
            if (pack_ready) begin
              addr_r <= addr_r + ADDR_ONE;
              if (col_end) begin
                col_cnt <= '0;
                if (tile_end) begin
                  state  <= DRAIN;
                  done_r <= 1'b1;
                end else begin
                  tile_cnt <= tile_cnt + TILE_ONE;
                end
              end else begin
                col_cnt <= col_cnt + COL_ONE;
              end
            end
          end
          DRAIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef COLUMN_FEED_PERF_EN
  logic [31:0] stall_r, issue_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_r <= '0;
      issue_r <= '0;
    end else if (state == IDLE && start && !abort && !cfg_zero) begin
      stall_r <= '0;
      issue_r <= '0;
    end else begin
      if (state == RUN && !pack_ready && stall_r != '1) stall_r <= stall_r + 32'd1;
      if (issue && issue_r != '1) issue_r <= issue_r + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_r;
  assign perf_issue_cycles = issue_r;
`endif

  assign rd_en        = issue;
  assign rd_addr      = addr_r;
  assign column_valid = cv_r;
  assign col_first    = first_r;
  assign col_last     = last_r;
  assign tile_last    = tl_r;
  assign busy         = (state != IDLE);
  assign done         = done_r;
  assign cfg_err      = err_r;

endmodule

// File: tb/tb_column_feed_ctrl.sv
// Directed bench for column_feed_ctrl: per-job traces are captured as cycle bitmaps
// (cycle 0 = start cycle) and compared against hand-computed constants.
module tb_column_feed_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, pack_ready;
  logic [9:0]  cfg_num_cols;
  logic [7:0]  cfg_num_tiles;
  logic [11:0] cfg_base_addr;
  logic        rd_en, column_valid, col_first, col_last, tile_last, busy, done, cfg_err;
  logic [11:0] rd_addr;
`ifdef COLUMN_FEED_PERF_EN
  logic [31:0] perf_stall_cycles, perf_issue_cycles;
`endif

  column_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_num_cols(cfg_num_cols), .cfg_num_tiles(cfg_num_tiles), .cfg_base_addr(cfg_base_addr),
    .pack_ready(pack_ready), .rd_en(rd_en), .rd_addr(rd_addr), .column_valid(column_valid),
    .col_first(col_first), .col_last(col_last), .tile_last(tile_last), .busy(busy), .done(done),
`ifdef COLUMN_FEED_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_issue_cycles(perf_issue_cycles),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] rd_map, cv_map, done_map, busy_map, err_map;
  logic [15:0] fmask, lmask, tmask;
  logic [11:0] addrs [16];
  int          n_rd, n_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs ncyc cycles starting with a start pulse at cycle 0.
  task automatic run(input logic [9:0] nc, input logic [7:0] nt, input logic [11:0] base,
                     input int stall_from, input int stall_len, input int abort_at,
                     input int restart_at, input int ncyc);
    rd_map = 0; cv_map = 0; done_map = 0; busy_map = 0; err_map = 0;
    fmask = 0; lmask = 0; tmask = 0; n_rd = 0; n_col = 0;
    for (int i = 0; i < 16; i++) addrs[i] = '0;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == restart_at);
      if (c == restart_at) begin
        cfg_num_cols = 10'd2; cfg_num_tiles = 8'd1; cfg_base_addr = 12'h300;
      end else begin
        cfg_num_cols = nc; cfg_num_tiles = nt; cfg_base_addr = base;
      end
      abort = (c == abort_at);
      pack_ready = !(c >= stall_from && c < stall_from + stall_len);
      #2;
      rd_map[c] = rd_en; cv_map[c] = column_valid; done_map[c] = done;
      busy_map[c] = busy; err_map[c] = cfg_err;
      if (rd_en && n_rd < 16) begin addrs[n_rd] = rd_addr; n_rd++; end
      if (column_valid && n_col < 16) begin
        fmask[n_col] = col_first; lmask[n_col] = col_last; tmask[n_col] = tile_last; n_col++;
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; pack_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pack_ready = 1'b1;
    cfg_num_cols = 10'd4; cfg_num_tiles = 8'd2; cfg_base_addr = 12'h010;
    tick(); tick();
    #2;
    chk("rst_outs", {rd_en, rd_addr, column_valid, col_first, col_last, tile_last, busy, done, cfg_err},
        32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 4x2 job, ready always high
    run(10'd4, 8'd2, 12'h010, 99, 0, -1, -1, 12);
    chk("t1_rd_map", rd_map, 32'h1FE);
    chk("t1_addr0", {20'h0, addrs[0]}, 32'h010);
    chk("t1_addr7", {20'h0, addrs[7]}, 32'h017);
    chk("t1_cv_map", cv_map, 32'h3FC);
    chk("t1_first", {16'h0, fmask}, 32'h11);
    chk("t1_last", {16'h0, lmask}, 32'h88);
    chk("t1_tlast", {16'h0, tmask}, 32'hF0);
    chk("t1_done", done_map, 32'h200);
    chk("t1_busy", busy_map, 32'h3FE);

    // Same job, ready low for cycles 3..5
    run(10'd4, 8'd2, 12'h010, 3, 3, -1, -1, 15);
    chk("t2_rd_map", rd_map, 32'hFC6);
    chk("t2_nrd", n_rd, 8);
    chk("t2_addr2", {20'h0, addrs[2]}, 32'h012);
    chk("t2_addr7", {20'h0, addrs[7]}, 32'h017);
    chk("t2_cv_map", cv_map, 32'h1F8C);
    chk("t2_done", done_map, 32'h1000);
`ifdef COLUMN_FEED_PERF_EN
    chk("t2_perf_stall", perf_stall_cycles, 32'd3);
    chk("t2_perf_issue", perf_issue_cycles, 32'd8);
`endif

    // Zero counts
    run(10'd0, 8'd2, 12'h010, 99, 0, -1, -1, 4);
    chk("z1_err", err_map, 32'h2);
    chk("z1_done", done_map, 32'h2);
    chk("z1_rd_busy", rd_map | busy_map, 32'h0);
    run(10'd3, 8'd0, 12'h010, 99, 0, -1, -1, 4);
    chk("z2_err", err_map, 32'h2);
    chk("z2_rd_busy_cv", rd_map | busy_map | cv_map, 32'h0);

    // Address wrap
    run(10'd4, 8'd1, 12'hFFE, 99, 0, -1, -1, 8);
    chk("w_rd_map", rd_map, 32'h1E);
    chk("w_addrs", {8'h0, addrs[0], addrs[1]}, {8'h0, 12'hFFE, 12'hFFF});
    chk("w_addrs2", {8'h0, addrs[2], addrs[3]}, {8'h0, 12'h000, 12'h001});
    chk("w_flags", {4'h0, fmask[3:0], lmask[3:0], tmask[3:0]}, {4'h0, 4'b0001, 4'b1000, 4'b1111});
    chk("w_done", done_map, 32'h20);

    // Single column per tile
    run(10'd1, 8'd3, 12'h005, 99, 0, -1, -1, 7);
    chk("c1_flags", {20'h0, fmask[2:0], 1'b0, lmask[2:0], 1'b0, tmask[2:0], 1'b0},
        {20'h0, 3'b111, 1'b0, 3'b111, 1'b0, 3'b100, 1'b0});
    chk("c1_done", done_map, 32'h10);

    // Abort after 3rd read, then immediate restart
    run(10'd4, 8'd2, 12'h020, 99, 0, 4, -1, 5);
    chk("ab_rd_map", rd_map, 32'hE);
    chk("ab_cv_map", cv_map, 32'h1C);
    chk("ab_done", done_map, 32'h0);
    run(10'd4, 8'd2, 12'h040, 99, 0, -1, -1, 12);
    chk("ab2_cv_map", cv_map, 32'h3FC);
    chk("ab2_busy", busy_map, 32'h3FE);
    chk("ab2_rd_map", rd_map, 32'h1FE);
    chk("ab2_addr0", {20'h0, addrs[0]}, 32'h040);
    chk("ab2_done", done_map, 32'h200);

    // Abort and start together in IDLE
    run(10'd4, 8'd2, 12'h040, 99, 0, 0, -1, 4);
    chk("as_all", rd_map | busy_map | cv_map | done_map | err_map, 32'h0);

    // Start re-pulsed mid-job with other config
    run(10'd4, 8'd2, 12'h050, 99, 0, -1, 3, 12);
    chk("rs_rd_map", rd_map, 32'h1FE);
    chk("rs_addr7", {20'h0, addrs[7]}, 32'h057);
    chk("rs_last", {16'h0, lmask}, 32'h88);
    chk("rs_done", done_map, 32'h200);

    // Reset mid-job
    start = 1'b1; cfg_num_cols = 10'd4; cfg_num_tiles = 8'd2; cfg_base_addr = 12'h060;
    tick(); start = 1'b0; tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    #2;
    chk("rm_outs", {rd_en, rd_addr, column_valid, busy, done}, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
